tt_tile_bist: RTL
=================

// Module: tt_tile_bist
// PURPOSE
//   Built-in self-test engine for a Tiny Tapeout user tile, run in-circuit with no external bench.
//   An LFSR drives pseudo-random stimulus into the DUT's dedicated inputs.
//   A MISR compacts the DUT's dedicated outputs into a signature and compares it to an expected value.
//   Sits beside tt_um_* projects. It is parametrised in lane width, run length and DUT response latency.
// PARAMETERS
//   WIDTH   8      stimulus/response lane count (>=2)
//   CYCLES  256    number of response samples compacted per run (>=1)
//   LAT     0      DUT response latency in clocks; samples start LAT cycles after first stimulus (>=0)
//   POLY    8'h1D  feedback polynomial for LFSR and MISR (WIDTH bits, x^WIDTH term implied)
//   SEED    8'h01  LFSR start value (WIDTH bits, must be nonzero)
// PORTS
//   clk        in   1      clock
//   rst_n      in   1      asynchronous active-low reset
//   ena        in   1      tile enable; 0 freezes all state (pause)
//   start      in   1      level-sampled run request
//   dut_out    in   WIDTH  DUT response (e.g. uo_out)
//   expected   in   WIDTH  golden signature, compared at end of run
//   stim       out  WIDTH  stimulus to DUT (e.g. ui_in)
//   busy       out  1      1 while in RUN
//   done       out  1      1 while in DONE
//   pass       out  1      valid when done=1: signature == expected
//   signature  out  WIDTH  current MISR contents
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, lfsr=SEED, misr=0, cnt=0, pass=0; stim=0, busy=0, done=0.
//   Every register update below occurs only on clk edges with ena=1; ena=0 holds all state and outputs.
//   Step function f(x) = (x<<1)[WIDTH-1:0] ^ (x[WIDTH-1] ? POLY : 0).
//   FSM states: IDLE, RUN, DONE.
//     IDLE: stim=0. If start=1, go to RUN with lfsr=SEED, misr=0, cnt=0.
//     RUN: stim=lfsr (registered; no combinational path from any input to stim).
//       At each edge: lfsr<=f(lfsr) and cnt<=cnt+1.
//       If cnt>=LAT, also misr<=f(misr)^dut_out.
//       At the edge where cnt==CYCLES+LAT-1 (last sample absorbed): go to DONE.
//         On that edge, pass<=(f(misr)^dut_out)==expected, i.e. the comparison uses the new signature.
//       start is ignored in RUN.
//       The run lasts exactly CYCLES+LAT cycles: stimulus k is applied in RUN cycle k.
//       The response to stimulus k is absorbed at the edge ending RUN cycle k+LAT.
//     DONE: stim=0. misr and pass are held.
//       If start=1, restart: go to RUN with lfsr=SEED, misr=0, cnt=0 (no IDLE visit).
//       If start=0, stay in DONE.
//   Outputs: busy=(state==RUN), done=(state==DONE), signature=misr in every state.
//   cnt width is $clog2(CYCLES+LAT+1); it never wraps inside a run.
//   The LFSR wraps per its period (255 for WIDTH=8/POLY=1D); the wrap is not an error.
//   Reset mid-run aborts immediately to the IDLE/reset values; no partial pass is reported.
//   ena deasserted mid-run pauses the run; resume is cycle-exact with no lost or duplicated sample.
//   expected may change at any time; only its value at the final RUN edge matters.
// TESTING  (WIDTH=8, POLY=8'h1D, SEED=8'h01 unless noted)
//   1 Reset/idle: hold rst_n=0, then release with start=0
//     -> stim=00, busy=0, done=0, pass=0, signature=00 for 10 cycles.
//   2 LFSR sequence: start pulse, CYCLES=16, dut_out tied 0
//     -> stim = 01,02,04,08,10,20,40,80,1D,3A on RUN cycles 0..9; signature stays 00.
//   3 Loopback dut_out=stim, LAT=0
//     -> CYCLES=1: signature=01. CYCLES=2: signature=00. CYCLES=3: signature=04.
//     -> pass=1 only when expected matches; busy high for exactly CYCLES cycles.
//   4 Constant dut_out=FF, CYCLES=2, LAT=0 -> signature=1C, done=1.
//     -> expected=1C gives pass=1; expected=1D gives pass=0.
//   5 Latency: LAT=2, CYCLES=1, loopback -> busy for 3 cycles, signature=04.
//   6 Disturbances:
//     -> ena=0 for 5 cycles mid-run (test 3, CYCLES=3): signature still 04.
//     -> rst_n pulse mid-run: immediate IDLE with reset outputs.
//     -> start held high through DONE: back-to-back runs, each with an identical signature.

Source files
------------

// File: rtl/tt_tile_bist.sv
// Self-test engine for a Tiny Tapeout tile: an LFSR drives stimulus into the DUT, and a MISR
// compacts the DUT responses into a signature that is checked against a golden value at end of run.
module tt_tile_bist #(
   parameter int unsigned          WIDTH  = 8,
   parameter int unsigned          CYCLES = 256,
   parameter int unsigned          LAT    = 0,
   parameter logic [WIDTH-1:0]     POLY   = WIDTH'(8'h1D),
   parameter logic [WIDTH-1:0]     SEED   = WIDTH'(8'h01)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] dut_out,
   input  logic [WIDTH-1:0] expected,
   output logic [WIDTH-1:0] stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   localparam int unsigned TOTAL = CYCLES + LAT;
   localparam int unsigned CW    = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
   localparam logic [CW-1:0] LAT_C = CW'(LAT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  lfsr;
   logic [WIDTH-1:0]  misr;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  misr_nxt_c;
   logic              sample_c;

   // Shared Galois step for both the stimulus LFSR and the response MISR.
   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
      return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
   endfunction

   assign misr_nxt_c = step(misr) ^ dut_out;

   // Responses only become meaningful once the DUT latency has elapsed.
   if (LAT == 0) begin : g_nolat
      assign sample_c = 1'b1;
   end else begin : g_lat
      assign sample_c = (cnt >= LAT_C);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lfsr  <= SEED;
         misr  <= '0;
         cnt   <= '0;
         pass  <= 1'b0;
         stim  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (ena) begin
         case (state)
            RUN: begin
               lfsr <= step(lfsr);
               stim <= step(lfsr);
               cnt  <= cnt + CW'(1);
               if (sample_c) begin
                  misr <= misr_nxt_c;
               end
               // Final sample: compare against the signature being written this edge.
               if (cnt == LAST) begin
                  state <= DONE;
                  pass  <= (misr_nxt_c == expected);
                  stim  <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            IDLE, DONE: begin
               stim <= '0;
               if (start) begin
                  state <= RUN;
                  lfsr  <= SEED;
                  stim  <= SEED;
                  misr  <= '0;
                  cnt   <= '0;
                  pass  <= 1'b0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               stim  <= '0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign signature = misr;

endmodule
